// File: rtl/arb_pkg.sv
// Shared constants and state type for the 32-way round-robin arbiter.
// The optional hold-timeout (macro RR_ARB_TIMEOUT_EN) uses ARB_MAX_HOLD as its default limit.
package arb_pkg;

    localparam int unsigned ARB_SIZE     = 5;
    localparam int unsigned ARB_N        = 32;
    localparam int unsigned ARB_MAX_HOLD = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/priorityencoder.sv
// Returns the index of the highest set bit of in_i; valid_o flags a non-empty vector.
module priorityencoder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign valid_o = |in_i;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 2**SIZE requesters; a grant is held until done_i or request drop.
// Defining RR_ARB_TIMEOUT_EN adds a hold counter that preempts a grant after MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned SIZE     = ARB_SIZE,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [2**SIZE-1:0]   req_i,
    input  logic                 done_i,
    output logic [2**SIZE-1:0]   gnt_o,
    output logic [SIZE-1:0]      gnt_id_o,
    output logic                 gnt_valid_o,
    output logic                 preempt_o
);

    localparam int unsigned N = 2**SIZE;

    arb_state_e      state_q;
    logic [SIZE-1:0] last_q;
    logic [N-1:0]    gnt_q;
    logic [SIZE-1:0] id_q;
    logic            valid_q;

    logic [N-1:0]    below_mask;
    logic [N-1:0]    masked;
    logic [SIZE-1:0] idx_masked;
    logic [SIZE-1:0] idx_raw;
    logic            vld_masked;
    logic            vld_raw;
    logic [SIZE-1:0] winner;
    logic            release_c;

    // Only requesters strictly below the previous winner get first pick.
    assign below_mask = (N'(1) << last_q) - N'(1);
    assign masked     = req_i & below_mask;

    priorityencoder #(
        .WIDTH (N),
        .IDX_W (SIZE)
    ) u_enc_masked (
        .in_i    (masked),
        .idx_o   (idx_masked),
        .valid_o (vld_masked)
    );

    priorityencoder #(
        .WIDTH (N),
        .IDX_W (SIZE)
    ) u_enc_raw (
        .in_i    (req_i),
        .idx_o   (idx_raw),
        .valid_o (vld_raw)
    );

    assign winner    = vld_masked ? idx_masked : idx_raw;
    assign release_c = done_i | ~req_i[id_q];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_q;
    logic             preempt_q;
    logic             hold_max;

    assign hold_max  = (hold_q == CNT_W'(MAX_HOLD));
    assign preempt_o = preempt_q;
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign preempt_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ARB_IDLE;
            last_q    <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q    <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            preempt_q <= 1'b0;
`endif
            unique case (state_q)
                ARB_IDLE: begin
                    if (vld_raw) begin
                        state_q <= ARB_GRANT;
                        gnt_q   <= N'(1) << winner;
                        id_q    <= winner;
                        valid_q <= 1'b1;
                        last_q  <= winner;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_q  <= CNT_W'(1);
`endif
                    end
                end
                ARB_GRANT: begin
                    if (release_c) begin
                        state_q <= ARB_IDLE;
                        gnt_q   <= '0;
                        id_q    <= '0;
                        valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
                    end else if (hold_max) begin
                        // A coinciding release takes the branch above, so no pulse there.
                        state_q   <= ARB_IDLE;
                        gnt_q     <= '0;
                        id_q      <= '0;
                        valid_q   <= 1'b0;
                        preempt_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + CNT_W'(1);
`endif
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = id_q;
    assign gnt_valid_o = valid_q;

endmodule
